// File: rtl/apb_slave_pkg.sv
// Shared types, register offsets and STATUS bit positions for the APB slave register bank.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } phase_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_RW,
    K_ID,
    K_WRCNT,
    K_RDCNT,
    K_STATUS
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [3:0] idx;
  } decode_t;

  localparam logic [7:0] OFS_ID     = 8'h40;
  localparam logic [7:0] OFS_WRCNT  = 8'h44;
  localparam logic [7:0] OFS_RDCNT  = 8'h48;
  localparam logic [7:0] OFS_STATUS = 8'h4C;

  localparam int ST_PROTO = 0;
  localparam int ST_ADDR  = 1;

endpackage

// File: rtl/apb_phase_tracker.sv
// Follows the initiator's SETUP/ACCESS sequencing, latches the SETUP address/direction
// and flags a completed ACCESS or a protocol violation as single-cycle pulses.
module apb_phase_tracker (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_paddr,
  output logic        o_setup_done,
  output logic        o_access_ok,
  output logic        o_proto_err,
  output logic        o_write,
  output logic [31:0] o_addr
);
  import apb_slave_pkg::*;

  phase_e      r_state;
  phase_e      w_nextState;
  logic [31:0] r_addr;
  logic        r_write;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (o_setup_done) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
      end
    end
  end

  // A SETUP state means the bus is now in its ACCESS cycle; address and direction must not move.
  always_comb begin
    w_nextState  = r_state;
    o_setup_done = 1'b0;
    o_access_ok  = 1'b0;
    o_proto_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_psel && !i_penable) begin
          w_nextState  = SETUP;
          o_setup_done = 1'b1;
        end else if (i_psel && i_penable) begin
          o_proto_err = 1'b1;
        end
      end
      SETUP: begin
        if (i_psel && i_penable && (i_paddr == r_addr) && (i_pwrite == r_write)) begin
          w_nextState = ACCESS;
          o_access_ok = 1'b1;
        end else begin
          o_proto_err = 1'b1;
          if (i_psel && !i_penable) begin
            w_nextState  = SETUP;
            o_setup_done = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      ACCESS: begin
        if (i_psel && !i_penable) begin
          w_nextState  = SETUP;
          o_setup_done = 1'b1;
        end else if (!i_psel) begin
          w_nextState = IDLE;
        end else begin
          o_proto_err = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign o_write = r_write;
  assign o_addr  = r_addr;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB2 responder for one bridge slot: RW register array, ID, transfer counters and
// sticky write-1-to-clear error status with a registered interrupt.
module apb_slave_regbank #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          WIN_BITS  = 26,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] ID_VALUE  = 32'hA2B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Err_irq
);
  import apb_slave_pkg::*;

  localparam logic [5:0] LP_NUM_WORDS = 6'(NUM_REGS);

  logic             w_setupDone;
  logic             w_accessOk;
  logic             w_protoErr;
  logic             w_latWrite;
  logic [31:0]      w_latAddr;
  decode_t          w_setupDec;
  decode_t          w_accessDec;
  logic [31:0]      w_rdValue;
  logic [1:0]       w_stSet;
  logic [1:0]       w_stClr;
  logic [31:0]      r_regs [NUM_REGS];
  logic [CNT_W-1:0] r_wrCount;
  logic [CNT_W-1:0] r_rdCount;
  logic [1:0]       r_status;
  logic [31:0]      r_prdata;
  logic             r_errIrq;

  apb_phase_tracker u_tracker (
    .i_clk        (Hclk),
    .i_rst_n      (Hresetn),
    .i_psel       (Psel),
    .i_penable    (Penable),
    .i_pwrite     (Pwrite),
    .i_paddr      (Paddr),
    .o_setup_done (w_setupDone),
    .o_access_ok  (w_accessOk),
    .o_proto_err  (w_protoErr),
    .o_write      (w_latWrite),
    .o_addr       (w_latAddr)
  );

  // Anything outside this slot's window, above offset 0xFF, or misaligned is unmapped.
  function automatic decode_t decodeAddr(input logic [31:0] addr);
    decode_t d;
    d.kind = K_NONE;
    d.idx  = addr[5:2];
    if ((addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) && (addr[WIN_BITS-1:8] == '0) &&
        (addr[1:0] == 2'b00)) begin
      if (addr[7:2] < LP_NUM_WORDS) begin
        d.kind = K_RW;
      end else begin
        case (addr[7:0])
          OFS_ID:     d.kind = K_ID;
          OFS_WRCNT:  d.kind = K_WRCNT;
          OFS_RDCNT:  d.kind = K_RDCNT;
          OFS_STATUS: d.kind = K_STATUS;
          default:    d.kind = K_NONE;
        endcase
      end
    end
    return d;
  endfunction

  assign w_setupDec  = decodeAddr(Paddr);
  assign w_accessDec = decodeAddr(w_latAddr);

  always_comb begin
    w_rdValue = '0;
    case (w_setupDec.kind)
      K_RW: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (4'(i) == w_setupDec.idx) w_rdValue = r_regs[i];
        end
      end
      K_ID:     w_rdValue = ID_VALUE;
      K_WRCNT:  w_rdValue[CNT_W-1:0] = r_wrCount;
      K_RDCNT:  w_rdValue[CNT_W-1:0] = r_rdCount;
      K_STATUS: w_rdValue[1:0] = r_status;
      default:  w_rdValue = '0;
    endcase
  end

  always_comb begin
    w_stSet           = '0;
    w_stClr           = '0;
    w_stSet[ST_PROTO] = w_protoErr;
    w_stSet[ST_ADDR]  = w_accessOk && (w_accessDec.kind == K_NONE);
    if (w_accessOk && w_latWrite && (w_accessDec.kind == K_STATUS)) w_stClr = Pwdata[1:0];
  end

  // Read data is captured as the bus leaves SETUP so it is stable for the whole ACCESS cycle.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_prdata  <= '0;
      r_status  <= '0;
      r_errIrq  <= 1'b0;
      r_wrCount <= '0;
      r_rdCount <= '0;
    end else begin
      r_prdata <= (w_setupDone && !Pwrite) ? w_rdValue : '0;
      r_status <= (r_status & ~w_stClr) | w_stSet;
      r_errIrq <= |r_status;
      if (w_accessOk) begin
        if (w_latWrite) r_wrCount <= r_wrCount + CNT_W'(1);
        else            r_rdCount <= r_rdCount + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_accessOk && w_latWrite && (w_accessDec.kind == K_RW)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (4'(i) == w_accessDec.idx) r_regs[i] <= Pwdata;
      end
    end
  end

  assign Prdata  = r_prdata;
  assign Err_irq = r_errIrq;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized scoreboard bench for apb_slave_regbank against a transaction-level register map model.
module tb_apb_slave_regbank;
  localparam int          NUM_REGS = 16;
  localparam int          CNT_W    = 8;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] IDV      = 32'hA2B0_0001;

  logic        Hclk;
  logic        Hresetn;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Err_irq;

  int          testsRun = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] mRegs [NUM_REGS];
  int          mWr;
  int          mRd;
  logic [1:0]  mStatus;

  apb_slave_regbank #(
    .NUM_REGS (NUM_REGS),
    .BASE_ADDR(BASE),
    .WIN_BITS (26),
    .CNT_W    (CNT_W),
    .ID_VALUE (IDV)
  ) dut (
    .Hclk   (Hclk),
    .Hresetn(Hresetn),
    .Psel   (Psel),
    .Penable(Penable),
    .Pwrite (Pwrite),
    .Paddr  (Paddr),
    .Pwdata (Pwdata),
    .Prdata (Prdata),
    .Err_irq(Err_irq)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL time_limit: got expired, want completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_REGS; i++) mRegs[i] = '0;
    mWr     = 0;
    mRd     = 0;
    mStatus = 2'b00;
  endfunction

  // Returns 0..NUM_REGS-1 for RW words, 16 ID, 17 WR_COUNT, 18 RD_COUNT, 19 STATUS, -1 unmapped.
  function automatic int modelDecode(input logic [31:0] a);
    int ofs;
    if ((a >> 26) != (BASE >> 26)) return -1;
    if (((a >> 8) & 32'h0003_FFFF) != 0) return -1;
    if ((a % 4) != 0) return -1;
    ofs = int'(a % 256);
    if (ofs < 4 * NUM_REGS) return ofs / 4;
    if (ofs == 64) return 16;
    if (ofs == 68) return 17;
    if (ofs == 72) return 18;
    if (ofs == 76) return 19;
    return -1;
  endfunction

  function automatic logic [31:0] modelTransfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int          k;
    logic [31:0] rd;
    k  = modelDecode(a);
    rd = '0;
    if (!wr) begin
      if (k >= 0 && k < NUM_REGS) rd = mRegs[k];
      else if (k == 16)           rd = IDV;
      else if (k == 17)           rd = 32'(mWr);
      else if (k == 18)           rd = 32'(mRd);
      else if (k == 19)           rd = {30'b0, mStatus};
    end else begin
      if (k >= 0 && k < NUM_REGS) mRegs[k] = d;
      if (k == 19)                mStatus = mStatus & ~d[1:0];
    end
    if (k < 0) mStatus[1] = 1'b1;
    if (wr) mWr = (mWr + 1) % (1 << CNT_W);
    else    mRd = (mRd + 1) % (1 << CNT_W);
    return rd;
  endfunction

  function automatic logic [31:0] randomAddr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: a = BASE | (32'($urandom_range(0, NUM_REGS - 1)) << 2);
      5:             a = BASE + 32'h40 + (32'($urandom_range(0, 3)) << 2);
      6:             a = BASE | (32'($urandom_range(20, 63)) << 2);
      7:             a = BASE | 32'($urandom_range(0, 32'h4F)) | 32'($urandom_range(1, 3));
      8:             a = BASE | (32'($urandom_range(1, 32'h3FFFF)) << 8) | (32'($urandom_range(0, 15)) << 2);
      default:       a = (BASE ^ (32'($urandom_range(1, 63)) << 26)) | (32'($urandom_range(0, 15)) << 2);
    endcase
    return a;
  endfunction

  // One well-formed transfer; ends with the bus idle so a following call runs back-to-back.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp;
    exp     = modelTransfer(wr, addr, data);
    Psel    = 1'b1;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = $urandom();
    @(posedge Hclk); #1;
    Penable = 1'b1;
    Pwdata  = data;
    if (!wr) expQ.push_back(exp);
    @(posedge Hclk); #1;
    Psel    = 1'b0;
    Penable = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    Psel    = 1'b0;
    Penable = 1'b0;
    Paddr   = $urandom();
    for (int i = 0; i < n; i++) begin
      @(posedge Hclk); #1;
    end
    if (n > 0) checkOutput("err_irq", {31'b0, Err_irq}, {31'b0, |mStatus});
  endtask

  initial begin
    forever begin
      @(negedge Hclk);
      if (Hresetn && Psel && Penable && !Pwrite) begin
        if (expQ.size() == 0) begin
          checkOutput("prdata_unexpected", Prdata, 32'hXXXX_XXXX);
        end else begin
          checkOutput("prdata", Prdata, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    bit wr;
    int gap;
    Hresetn = 1'b0;
    Psel    = 1'b0;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    modelReset();
    repeat (3) @(posedge Hclk);
    #1;
    checkOutput("reset_prdata", Prdata, 32'h0);
    checkOutput("reset_err_irq", {31'b0, Err_irq}, 32'h0);
    Hresetn = 1'b1;
    idleCycles(1);

    applyStimulus(1'b1, BASE + 32'h08, 32'h1234_5678);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0);
    applyStimulus(1'b0, BASE + 32'h48, 32'h0);
    applyStimulus(1'b0, BASE + 32'h44, 32'h0);
    idleCycles(1);

    applyStimulus(1'b0, BASE + 32'h40, 32'h0);
    applyStimulus(1'b1, BASE + 32'h40, 32'h0);
    applyStimulus(1'b0, BASE + 32'h40, 32'h0);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    idleCycles(2);

    applyStimulus(1'b1, BASE, 32'h0000_00AA);
    applyStimulus(1'b0, BASE, 32'h0);
    idleCycles(1);

    for (int n = 0; n < 300; n++) begin
      wr  = 1'($urandom_range(0, 1));
      applyStimulus(wr, randomAddr(), $urandom());
      gap = $urandom_range(0, 2);
      if (gap != 0) idleCycles(gap);
    end
    idleCycles(1);

    applyStimulus(1'b1, BASE + 32'h4C, 32'h3);
    idleCycles(1);

    // Penable raised without a SETUP cycle.
    Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b1; Paddr = BASE + 32'h0C; Pwdata = 32'hBAD0_0001;
    @(posedge Hclk); #1;
    mStatus[0] = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, BASE + 32'h0C, 32'h0);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    applyStimulus(1'b1, BASE + 32'h4C, 32'h1);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    idleCycles(1);

    // Address moves between SETUP and ACCESS.
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h10; Pwdata = $urandom();
    @(posedge Hclk); #1;
    Penable = 1'b1; Paddr = BASE + 32'h14; Pwdata = 32'hFFFF_FFFF;
    @(posedge Hclk); #1;
    mStatus[0] = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0);
    applyStimulus(1'b0, BASE + 32'h14, 32'h0);
    applyStimulus(1'b0, BASE + 32'h100, 32'h0);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    applyStimulus(1'b1, BASE + 32'h4C, 32'h3);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    idleCycles(1);

    // Penable held for two cycles on a write to the read-only ID register.
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h40; Pwdata = $urandom();
    @(posedge Hclk); #1;
    Penable = 1'b1; Pwdata = 32'h0;
    void'(modelTransfer(1'b1, BASE + 32'h40, 32'h0));
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    mStatus[0] = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    applyStimulus(1'b0, BASE + 32'h40, 32'h0);
    idleCycles(1);

    // Reset asserted in the middle of a read ACCESS cycle.
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = BASE + 32'h08;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    expQ.push_back(modelTransfer(1'b0, BASE + 32'h08, 32'h0));
    @(negedge Hclk); #2;
    Hresetn = 1'b0;
    #1;
    checkOutput("async_reset_prdata", Prdata, 32'h0);
    checkOutput("async_reset_err_irq", {31'b0, Err_irq}, 32'h0);
    modelReset();
    @(posedge Hclk); #1;
    Psel = 1'b0; Penable = 1'b0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    idleCycles(1);
    for (int i = 0; i < NUM_REGS; i++) applyStimulus(1'b0, BASE + 32'(4 * i), 32'h0);
    applyStimulus(1'b0, BASE + 32'h44, 32'h0);
    applyStimulus(1'b0, BASE + 32'h48, 32'h0);
    applyStimulus(1'b0, BASE + 32'h4C, 32'h0);
    idleCycles(1);

    while (mWr != (1 << CNT_W) - 1) begin
      applyStimulus(1'b1, BASE + (32'($urandom_range(0, NUM_REGS - 1)) << 2), $urandom());
    end
    applyStimulus(1'b0, BASE + 32'h44, 32'h0);
    applyStimulus(1'b1, BASE, 32'h5A5A_5A5A);
    applyStimulus(1'b0, BASE + 32'h44, 32'h0);
    applyStimulus(1'b0, BASE, 32'h0);
    idleCycles(2);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
